// File: rtl/receptor_jogada_serial_pkg.sv
// Shared types and constants for the serial move receiver.
// RX_PARITY_EN enables the even-parity bit between data and stop.
package receptor_jogada_serial_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_START  = 4'd1,
    ST_DATA   = 4'd2,
    ST_PARITY = 4'd3,
    ST_STOP   = 4'd4,
    ST_DECODE = 4'd5
  } estado_t;

  localparam logic [7:0] ASCII_UM   = 8'h31;
  localparam logic [7:0] ASCII_NOVE = 8'h39;

  function automatic logic paridade_par(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/receptor_jogada_serial_ascii_para_botoes.sv
// Combinational ASCII '1'..'9' to one-hot button word.
// Output format matches the physical board buttons.
module ascii_para_botoes
  import receptor_jogada_serial_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       valido_o,
  output logic [8:0] botoes_o
);

  always_comb begin
    valido_o = (byte_i >= ASCII_UM) && (byte_i <= ASCII_NOVE);
    botoes_o = '0;
    // Low nibble is 1..9 whenever the byte is in range.
    if (valido_o)
      botoes_o = 9'd1 << (byte_i[3:0] - 4'd1);
  end

endmodule

// File: rtl/receptor_jogada_serial.sv
// UART receiver turning remote ASCII moves into held button words.
// Define RX_PARITY_EN to add an even-parity bit and erro_paridade.
module receptor_jogada_serial
  import receptor_jogada_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int HOLD_CYCLES  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [8:0] botoes,
  output logic       jogada_valida,
  output logic       erro_quadro,
  output logic       erro_char,
  output logic       erro_overrun,
`ifdef RX_PARITY_EN
  output logic       erro_paridade,
`endif
  output logic       ocupado,
  output logic [3:0] db_estado
);

  localparam int SW = $clog2(CLKS_PER_BIT);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [SW-1:0] BIT_FULL = SW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] BIT_HALF = SW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [HW-1:0] HOLD_INI = HW'(HOLD_CYCLES);

  logic [1:0]    sync_q;
  logic          rx_s;
  estado_t       estado_q, estado_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          armado_q, armado_d;
  logic [8:0]    botoes_q, botoes_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          valida_q, valida_d;
  logic          quadro_q, quadro_d;
  logic          char_q, char_d;
  logic          overrun_q, overrun_d;
  logic          par_bad;
  logic          byte_ok;
  logic [8:0]    byte_oh;

`ifdef RX_PARITY_EN
  logic          par_err_q, par_err_d;
  logic          paridade_q, paridade_d;
  assign par_bad = par_err_q;
`else
  assign par_bad = 1'b0;
`endif

  assign rx_s = sync_q[1];

  ascii_para_botoes u_dec (
    .byte_i   (shift_q),
    .valido_o (byte_ok),
    .botoes_o (byte_oh)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q    <= 2'b11;
      estado_q  <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      armado_q  <= 1'b1;
      botoes_q  <= '0;
      hold_q    <= '0;
      valida_q  <= 1'b0;
      quadro_q  <= 1'b0;
      char_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef RX_PARITY_EN
      par_err_q  <= 1'b0;
      paridade_q <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], rx};
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      armado_q  <= armado_d;
      botoes_q  <= botoes_d;
      hold_q    <= hold_d;
      valida_q  <= valida_d;
      quadro_q  <= quadro_d;
      char_q    <= char_d;
      overrun_q <= overrun_d;
`ifdef RX_PARITY_EN
      par_err_q  <= par_err_d;
      paridade_q <= paridade_d;
`endif
    end
  end

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    armado_d  = armado_q;
    botoes_d  = botoes_q;
    hold_d    = hold_q;
    valida_d  = 1'b0;
    quadro_d  = 1'b0;
    char_d    = 1'b0;
    overrun_d = 1'b0;
`ifdef RX_PARITY_EN
    par_err_d  = par_err_q;
    paridade_d = 1'b0;
`endif

    // Hold engine: independent of reception.
    if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
      if (hold_q == HW'(1))
        botoes_d = '0;
    end

    unique case (estado_q)
      ST_IDLE: begin
        // A break must see the line idle again before re-arming.
        if (rx_s) begin
          armado_d = 1'b1;
        end else if (armado_q) begin
          estado_d = ST_START;
          cnt_d    = BIT_HALF;
        end
      end
      ST_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SW'(1);
        end else if (rx_s) begin
          estado_d = ST_IDLE;
        end else begin
          estado_d = ST_DATA;
          cnt_d    = BIT_FULL;
          bit_d    = 3'd0;
        end
      end
      ST_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SW'(1);
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          cnt_d   = BIT_FULL;
          if (bit_q == 3'd7)
`ifdef RX_PARITY_EN
            estado_d = ST_PARITY;
`else
            estado_d = ST_STOP;
`endif
        end
      end
      ST_PARITY: begin
`ifdef RX_PARITY_EN
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SW'(1);
        end else begin
          par_err_d = rx_s ^ paridade_par(shift_q);
          cnt_d     = BIT_FULL;
          estado_d  = ST_STOP;
        end
`else
        estado_d = ST_IDLE;
`endif
      end
      ST_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SW'(1);
        end else if (!rx_s) begin
          quadro_d = 1'b1;
          armado_d = 1'b0;
          estado_d = ST_IDLE;
        end else begin
          estado_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        estado_d = ST_IDLE;
        if (par_bad) begin
`ifdef RX_PARITY_EN
          paridade_d = 1'b1;
`endif
        end else if (byte_ok) begin
          if (hold_q != '0) begin
            overrun_d = 1'b1;
          end else begin
            botoes_d = byte_oh;
            hold_d   = HOLD_INI;
            valida_d = 1'b1;
          end
        end else begin
          char_d = 1'b1;
        end
      end
      default: estado_d = ST_IDLE;
    endcase
  end

  assign botoes        = botoes_q;
  assign jogada_valida = valida_q;
  assign erro_quadro   = quadro_q;
  assign erro_char     = char_q;
  assign erro_overrun  = overrun_q;
`ifdef RX_PARITY_EN
  assign erro_paridade = paridade_q;
`endif
  assign ocupado       = (estado_q != ST_IDLE);
  assign db_estado     = estado_q;

endmodule

// File: tb/tb_receptor_jogada_serial.sv
// Scoreboard bench: two receivers with short and long hold times
// share one serial line; a frame-level model predicts each event.
module tb_receptor_jogada_serial;

  localparam int CPB = 8;
  localparam int HA  = 4;
  localparam int HB  = 120;

  localparam int EV_VAL = 1 << 16;
  localparam int EV_QUA = 2 << 16;
  localparam int EV_CHR = 3 << 16;
  localparam int EV_OVR = 4 << 16;
  localparam int EV_PAR = 5 << 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;

  always #5 clk = ~clk;

  logic [8:0] bot [2];
  logic       jv  [2];
  logic       eq  [2];
  logic       ec  [2];
  logic       eo  [2];
  logic       ep  [2];
  logic       oc  [2];
  logic [3:0] st  [2];

  receptor_jogada_serial #(.CLKS_PER_BIT(CPB), .HOLD_CYCLES(HA)) dut_a (
    .clock(clk), .reset(rst_n), .rx(rx),
    .botoes(bot[0]), .jogada_valida(jv[0]),
    .erro_quadro(eq[0]), .erro_char(ec[0]), .erro_overrun(eo[0]),
`ifdef RX_PARITY_EN
    .erro_paridade(ep[0]),
`endif
    .ocupado(oc[0]), .db_estado(st[0])
  );

  receptor_jogada_serial #(.CLKS_PER_BIT(CPB), .HOLD_CYCLES(HB)) dut_b (
    .clock(clk), .reset(rst_n), .rx(rx),
    .botoes(bot[1]), .jogada_valida(jv[1]),
    .erro_quadro(eq[1]), .erro_char(ec[1]), .erro_overrun(eo[1]),
`ifdef RX_PARITY_EN
    .erro_paridade(ep[1]),
`endif
    .ocupado(oc[1]), .db_estado(st[1])
  );

`ifndef RX_PARITY_EN
  assign ep[0] = 1'b0;
  assign ep[1] = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int q0[$];
  int q1[$];
  longint cyc = 0;
  longint last_acc [2];
  int run_len [2];
  logic [8:0] prev_bot [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input int got, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic push(input int k, input int e);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Frame-level prediction: one event per completed frame.
  task automatic model(input logic [7:0] b, input bit stop_ok,
                       input bit par_ok, input longint s);
    for (int k = 0; k < 2; k++) begin
      int h;
      h = (k == 0) ? HA : HB;
      if (!stop_ok) push(k, EV_QUA);
      else if (!par_ok) push(k, EV_PAR);
      else if (b >= 8'h31 && b <= 8'h39) begin
        if (s - last_acc[k] <= longint'(h)) push(k, EV_OVR);
        else begin
          push(k, EV_VAL | (1 << (int'(b) - 'h31)));
          last_acc[k] = s;
        end
      end else push(k, EV_CHR);
    end
  endtask

  task automatic mon(input int k);
    int n;
    int obs;
    int e;
    if (!rst_n) begin
      run_len[k] = 0;
      prev_bot[k] = '0;
      return;
    end
    n = int'(jv[k]) + int'(eq[k]) + int'(ec[k]) + int'(eo[k]) + int'(ep[k]);
    if (n != 0) begin
      chk(n == 1, "pulse_exclusive", n, 1);
      if (jv[k]) obs = EV_VAL | int'(bot[k]);
      else if (eq[k]) obs = EV_QUA;
      else if (ec[k]) obs = EV_CHR;
      else if (eo[k]) obs = EV_OVR;
      else obs = EV_PAR;
      if (k == 0 ? q0.size() == 0 : q1.size() == 0) begin
        chk(1'b0, "unexpected_event", obs, 0);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk(obs == e, k == 0 ? "event_a" : "event_b", obs, e);
      end
      if (jv[k]) chk(prev_bot[k] == 0, "valid_edge", int'(prev_bot[k]), 0);
    end
    if (bot[k] != '0) begin
      run_len[k]++;
      if (run_len[k] == 1)
        chk($countones(bot[k]) == 1, "onehot", int'(bot[k]), 1);
    end else if (run_len[k] > 0) begin
      chk(run_len[k] == ((k == 0) ? HA : HB), "hold_len",
          run_len[k], (k == 0) ? HA : HB);
      run_len[k] = 0;
    end
    prev_bot[k] = bot[k];
  endtask

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) mon(k);
  end

  task automatic waitc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok,
                      input bit par_ok, input int gap);
    model(b, stop_ok, par_ok, cyc);
    rx = 1'b0;
    waitc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      waitc(CPB);
    end
`ifdef RX_PARITY_EN
    rx = par_ok ? ^b : ~^b;
    waitc(CPB);
`endif
    rx = stop_ok;
    waitc(CPB);
    rx = 1'b1;
    waitc(stop_ok ? gap : gap + 16);
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk(bot[k] == '0, {tag, "_botoes"}, int'(bot[k]), 0);
      chk(!(jv[k] | eq[k] | ec[k] | eo[k] | ep[k]), {tag, "_pulses"},
          int'({jv[k], eq[k], ec[k], eo[k], ep[k]}), 0);
      chk(!oc[k], {tag, "_ocupado"}, int'(oc[k]), 0);
      chk(st[k] == 4'd0, {tag, "_estado"}, int'(st[k]), 0);
    end
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    last_acc[0] = -1000000;
    last_acc[1] = -1000000;
  endtask

  initial begin
    logic [7:0] b7;
    logic [7:0] rb;
    bit sok;
    bit pok;
    int g;
    clear_model();
    rst_n = 1'b0;
    rx = 1'b1;
    waitc(3);
    chk_zero("reset");
    rst_n = 1'b1;
    waitc(10);

    send(8'h35, 1'b1, 1'b1, 40);
    send(8'h31, 1'b1, 1'b1, 0);
    send(8'h39, 1'b1, 1'b1, 200);
    send(8'h41, 1'b1, 1'b1, 20);
    send(8'h35, 1'b0, 1'b1, 30);

    rx = 1'b0;
    waitc(2);
    rx = 1'b1;
    waitc(30);
    chk(oc[0] == 1'b0, "glitch_idle", int'(oc[0]), 0);
    send(8'h33, 1'b1, 1'b1, 200);

    send(8'h38, 1'b1, 1'b1, 0);
    b7 = 8'h37;
    rx = 1'b0;
    waitc(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b7[i];
      waitc(CPB);
    end
    rx = b7[4];
    waitc(CPB / 2);
    chk(oc[0] == 1'b1, "busy_mid_frame", int'(oc[0]), 1);
    chk(bot[1] == 9'h080, "held_before_rst", int'(bot[1]), 'h80);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    chk_zero("async_rst");
    waitc(3);
    clear_model();
    rst_n = 1'b1;
    waitc(20);
    send(8'h32, 1'b1, 1'b1, 200);

    model(8'h00, 1'b0, 1'b1, cyc);
    rx = 1'b0;
    waitc(200);
    rx = 1'b1;
    waitc(200);

`ifdef RX_PARITY_EN
    send(8'h33, 1'b1, 1'b0, 200);
    send(8'h33, 1'b1, 1'b1, 200);
`endif

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 6) rb = 8'h31 + 8'($urandom_range(0, 8));
      else rb = 8'($urandom_range(0, 255));
      sok = ($urandom_range(0, 9) != 0);
`ifdef RX_PARITY_EN
      pok = ($urandom_range(0, 7) != 0);
`else
      pok = 1'b1;
`endif
      if ($urandom_range(0, 1) == 0) g = int'($urandom_range(0, 6));
      else g = int'($urandom_range(60, 100));
      send(rb, sok, pok, g);
    end

    waitc(300);
    chk(q0.size() == 0, "pending_a", q0.size(), 0);
    chk(q1.size() == 0, "pending_b", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
